// File: rtl/mem_stage.sv
// mem_stage: MEM stage of the 5-stage RV32I pipeline, between ex_mem and mem_wb.
// Loads and stores run one byte per cycle over a byte-wide little-endian RAM port.
// Load data is sign- or zero-extended and returned on the rd write-back triple.
//
// Ports
//   clk, rst                  clock; synchronous active-high reset
//   rd_data_i/rd_addr_i/rd_enable_i  write-back triple from ex_mem
//   mem_op_i                  0 NONE,1 LB,2 LH,3 LW,4 LBU,5 LHU,6 SB,7 SH,8 SW, else NONE
//   mem_addr_i, st_data_i     effective address, store data
//   rd_data_o/rd_addr_o/rd_enable_o  write-back triple to mem_wb
//   stall_req_o               hold request to the stall controller
//   ram_a_o, ram_wr_o, ram_dout_o, ram_din_i  byte RAM port (read data one cycle late)
//   misalign_o                misaligned-access pulse
//
// Configuration
//   MEM_MISALIGN_TRAP_EN: misaligned LH/LHU/SH/LW/SW are rejected with a one-cycle
//   misalign_o pulse and no RAM access. Undefined: they run byte-serially as given.
module mem_stage #(
  parameter int unsigned ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       rd_data_i,
  input  logic [4:0]        rd_addr_i,
  input  logic              rd_enable_i,
  input  logic [3:0]        mem_op_i,
  input  logic [31:0]       mem_addr_i,
  input  logic [31:0]       st_data_i,
  output logic [31:0]       rd_data_o,
  output logic [4:0]        rd_addr_o,
  output logic              rd_enable_o,
  output logic              stall_req_o,
  output logic [ADDR_W-1:0] ram_a_o,
  output logic              ram_wr_o,
  output logic [7:0]        ram_dout_o,
  input  logic [7:0]        ram_din_i,
  output logic              misalign_o
);

  localparam logic [3:0] OpLb  = 4'd1;
  localparam logic [3:0] OpLh  = 4'd2;
  localparam logic [3:0] OpLbu = 4'd4;
  localparam logic [3:0] OpLhu = 4'd5;

  typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

  // Access size in bytes; 0 means no memory operation.
  function automatic logic [2:0] op_size(input logic [3:0] op);
    case (op)
      4'd1, 4'd4, 4'd6: op_size = 3'd1;
      4'd2, 4'd5, 4'd7: op_size = 3'd2;
      4'd3, 4'd8:       op_size = 3'd4;
      default:          op_size = 3'd0;
    endcase
  endfunction

  function automatic logic is_load(input logic [3:0] op);
    is_load = (op >= 4'd1) && (op <= 4'd5);
  endfunction

  function automatic logic is_store(input logic [3:0] op);
    is_store = (op >= 4'd6) && (op <= 4'd8);
  endfunction

  state_e             state_q, state_d;
  logic [2:0]         cnt_q, cnt_d;
  logic [3:0]         op_q;
  logic [ADDR_W-1:0]  addr_q;
  logic [31:0]        st_q;
  logic [31:0]        buf_q;
  logic [4:0]         rd_addr_q;
  logic               rd_en_q;

  logic               misaligned;
  logic               start;
  logic [1:0]         cap_idx;
  logic [31:0]        load_ext;

`ifdef MEM_MISALIGN_TRAP_EN
  assign misaligned = ((op_size(mem_op_i) == 3'd2) && mem_addr_i[0]) ||
                      ((op_size(mem_op_i) == 3'd4) && (mem_addr_i[1:0] != 2'b00));
`else
  assign misaligned = 1'b0;
`endif

  assign start      = (state_q == StIdle) && (op_size(mem_op_i) != 3'd0) && !misaligned && !rst;
  assign misalign_o = (state_q == StIdle) && misaligned && !rst;
  // Byte k-1 returns while cnt is k, since read data lags the address by a cycle.
  assign cap_idx    = cnt_q[1:0] - 2'd1;

  always_comb begin
    load_ext = buf_q;
    case (op_q)
      OpLb:    load_ext = {{24{buf_q[7]}}, buf_q[7:0]};
      OpLh:    load_ext = {{16{buf_q[15]}}, buf_q[15:0]};
      OpLbu:   load_ext = {24'b0, buf_q[7:0]};
      OpLhu:   load_ext = {16'b0, buf_q[15:0]};
      default: load_ext = buf_q;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rd_data_o   = rd_data_i;
    rd_addr_o   = rd_addr_i;
    rd_enable_o = rd_enable_i;
    stall_req_o = 1'b0;
    ram_a_o     = '0;
    ram_wr_o    = 1'b0;
    ram_dout_o  = 8'h00;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          ram_a_o     = mem_addr_i[ADDR_W-1:0];
          ram_wr_o    = is_store(mem_op_i);
          ram_dout_o  = st_data_i[7:0];
          stall_req_o = 1'b1;
          rd_enable_o = 1'b0;
          state_d     = StBusy;
          cnt_d       = 3'd1;
        end else if (misalign_o) begin
          rd_enable_o = 1'b0;
        end
      end
      StBusy: begin
        rd_enable_o = 1'b0;
        // Stall covers the start cycle plus BUSY cycles that still issue a byte,
        // so it is high for exactly N cycles; the final BUSY cycle only collects data.
        if (cnt_q < op_size(op_q)) begin
          ram_a_o     = addr_q + ADDR_W'(cnt_q);
          ram_wr_o    = is_store(op_q);
          ram_dout_o  = st_q[{cnt_q[1:0], 3'b000} +: 8];
          stall_req_o = 1'b1;
          cnt_d       = cnt_q + 3'd1;
        end else begin
          state_d = StDone;
        end
      end
      StDone: begin
        rd_data_o   = load_ext;
        rd_addr_o   = rd_addr_q;
        rd_enable_o = is_load(op_q) && rd_en_q && (rd_addr_q != 5'd0);
        state_d     = StIdle;
        cnt_d       = 3'd0;
      end
      default: begin
        state_d = StIdle;
        cnt_d   = 3'd0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      cnt_q     <= 3'd0;
      op_q      <= 4'd0;
      addr_q    <= '0;
      st_q      <= 32'h0;
      buf_q     <= 32'h0;
      rd_addr_q <= 5'd0;
      rd_en_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (start) begin
        op_q      <= mem_op_i;
        addr_q    <= mem_addr_i[ADDR_W-1:0];
        st_q      <= st_data_i;
        rd_addr_q <= rd_addr_i;
        rd_en_q   <= rd_enable_i;
        buf_q     <= 32'h0;
      end
      if ((state_q == StBusy) && is_load(op_q)) begin
        buf_q[{cap_idx, 3'b000} +: 8] <= ram_din_i;
      end
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed cases plus random operations checked
// against a transaction-level model (byte array + per-op expected cycle behaviour).
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] rd_data_i;
  logic [4:0]  rd_addr_i;
  logic        rd_en_i;
  logic [3:0]  mem_op;
  logic [31:0] mem_addr;
  logic [31:0] st_data;
  logic [31:0] rd_data_o;
  logic [4:0]  rd_addr_o;
  logic        rd_enable_o;
  logic        stall;
  logic [31:0] ram_a;
  logic        ram_wr;
  logic [7:0]  ram_dout;
  logic [7:0]  ram_din;
  logic        misalign;

  int tests = 0;
  int fails = 0;

  bit [7:0] ram     [1024];
  bit [7:0] ref_mem [1024];

  mem_stage #(.ADDR_W(32)) dut (
    .clk         (clk),
    .rst         (rst),
    .rd_data_i   (rd_data_i),
    .rd_addr_i   (rd_addr_i),
    .rd_enable_i (rd_en_i),
    .mem_op_i    (mem_op),
    .mem_addr_i  (mem_addr),
    .st_data_i   (st_data),
    .rd_data_o   (rd_data_o),
    .rd_addr_o   (rd_addr_o),
    .rd_enable_o (rd_enable_o),
    .stall_req_o (stall),
    .ram_a_o     (ram_a),
    .ram_wr_o    (ram_wr),
    .ram_dout_o  (ram_dout),
    .ram_din_i   (ram_din),
    .misalign_o  (misalign)
  );

  always #5 clk = ~clk;

  // Byte RAM, 1 KiB aliased over the address space; read data one cycle late.
  always @(posedge clk) begin
    if (ram_wr) ram[ram_a[9:0]] <= ram_dout;
    ram_din <= ram[ram_a[9:0]];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic int op_bytes(input logic [3:0] op);
    case (op)
      4'd1, 4'd4, 4'd6: return 1;
      4'd2, 4'd5, 4'd7: return 2;
      4'd3, 4'd8:       return 4;
      default:          return 0;
    endcase
  endfunction

  function automatic bit op_is_load(input logic [3:0] op);
    return (op >= 4'd1) && (op <= 4'd5);
  endfunction

  function automatic bit op_is_store(input logic [3:0] op);
    return (op >= 4'd6) && (op <= 4'd8);
  endfunction

  // Expected load result from the reference memory.
  function automatic logic [31:0] model_load(input logic [3:0] op, input logic [31:0] addr);
    logic [31:0] a;
    logic [31:0] v;
    v = 32'h0;
    for (int i = 0; i < 4; i++) begin
      a = addr + 32'(i);
      v[8*i +: 8] = ref_mem[a[9:0]];
    end
    case (op)
      4'd1:    return 32'($signed(v[7:0]));
      4'd2:    return 32'($signed(v[15:0]));
      4'd4:    return {24'h0, v[7:0]};
      4'd5:    return {16'h0, v[15:0]};
      default: return v;
    endcase
  endfunction

  // Called just after a posedge; returns just after the posedge ending the operation.
  task automatic run_op(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] st,
                        input logic [31:0] alu, input logic [4:0] rd, input logic en);
    int          n;
    bit          mis;
    logic [31:0] exp_ld;
    logic [31:0] a;
    n = op_bytes(op);
    mem_op = op; mem_addr = addr; st_data = st; rd_data_i = alu; rd_addr_i = rd; rd_en_i = en;
    mis = 1'b0;
`ifdef MEM_MISALIGN_TRAP_EN
    mis = ((n == 2) && addr[0]) || ((n == 4) && (addr[1:0] != 2'b00));
`endif
    if ((n == 0) || mis) begin
      @(negedge clk);
      if (!mis) begin
        check("pass_data", rd_data_o, alu);
        check("pass_addr", 32'(rd_addr_o), 32'(rd));
      end
      check("pass_en", 32'(rd_enable_o), mis ? 32'd0 : 32'(en));
      check("pass_stall", 32'(stall), 32'd0);
      check("pass_wr", 32'(ram_wr), 32'd0);
      check("misalign", 32'(misalign), 32'(mis));
      @(posedge clk); #1;
      return;
    end
    exp_ld = model_load(op, addr);
    for (int c = 0; c <= n + 1; c++) begin
      @(negedge clk);
      check("stall", 32'(stall), 32'(c < n));
      check("wr", 32'(ram_wr), 32'(op_is_store(op) && (c < n)));
      if (c < n) begin
        check("ram_a", ram_a, addr + 32'(c));
        if (op_is_store(op)) check("ram_dout", 32'(ram_dout), 32'(st[8*c +: 8]));
      end
      if (c <= n) begin
        check("busy_en", 32'(rd_enable_o), 32'd0);
      end else if (op_is_load(op)) begin
        check("ld_data", rd_data_o, exp_ld);
        check("ld_rd", 32'(rd_addr_o), 32'(rd));
        check("ld_en", 32'(rd_enable_o), 32'(en && (rd != 5'd0)));
      end else begin
        check("st_en", 32'(rd_enable_o), 32'd0);
      end
      @(posedge clk); #1;
    end
    if (op_is_store(op)) begin
      for (int i = 0; i < n; i++) begin
        a = addr + 32'(i);
        ref_mem[a[9:0]] = st[8*i +: 8];
      end
    end
    mem_op = 4'd0;
  endtask

  initial begin
    logic [3:0]  op;
    logic [31:0] addr;
    rst = 1'b1;
    mem_op = 4'd0; mem_addr = 32'h0; st_data = 32'h0;
    rd_data_i = 32'hCAFE_0001; rd_addr_i = 5'd7; rd_en_i = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_stall", 32'(stall), 32'd0);
    check("rst_wr", 32'(ram_wr), 32'd0);
    check("rst_a", ram_a, 32'h0);
    check("rst_dout", 32'(ram_dout), 32'd0);
    check("rst_mis", 32'(misalign), 32'd0);
    check("rst_data", rd_data_o, 32'hCAFE_0001);
    check("rst_en", 32'(rd_enable_o), 32'd1);
    @(posedge clk); #1;
    rst = 1'b0;

    run_op(4'd8, 32'h100, 32'hDEAD_BEEF, 32'h0, 5'd0, 1'b0);   // SW
    run_op(4'd3, 32'h100, 32'h0, 32'h0, 5'd5, 1'b1);           // LW x5
    run_op(4'd1, 32'h103, 32'h0, 32'h0, 5'd6, 1'b1);           // LB
    run_op(4'd4, 32'h103, 32'h0, 32'h0, 5'd7, 1'b1);           // LBU
    run_op(4'd2, 32'h102, 32'h0, 32'h0, 5'd8, 1'b1);           // LH
    run_op(4'd0, 32'h0, 32'h0, 32'h1234_5678, 5'd3, 1'b1);     // ALU pass
    run_op(4'd3, 32'h100, 32'h0, 32'h0, 5'd0, 1'b1);           // LW to x0
    run_op(4'd3, 32'h101, 32'h0, 32'h0, 5'd9, 1'b1);           // misaligned LW
    run_op(4'd8, 32'hFFFF_FFFE, 32'h0102_0304, 32'h0, 5'd0, 1'b0); // wrap
    run_op(4'd3, 32'hFFFF_FFFE, 32'h0, 32'h0, 5'd10, 1'b1);

    // Reset during the second cycle of a SW: only bytes 0 and 1 land.
    run_op(4'd8, 32'h200, 32'hAABB_CCDD, 32'h0, 5'd0, 1'b0);
    mem_op = 4'd8; mem_addr = 32'h200; st_data = 32'h1122_3344;
    @(negedge clk);
    check("mr_wr0", 32'(ram_wr), 32'd1);
    check("mr_d0", 32'(ram_dout), 32'h44);
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    check("mr_a1", ram_a, 32'h201);
    check("mr_d1", 32'(ram_dout), 32'h33);
    @(posedge clk); #1;
    rst = 1'b0;
    mem_op = 4'd0;
    @(negedge clk);
    check("mr_stall", 32'(stall), 32'd0);
    check("mr_wr", 32'(ram_wr), 32'd0);
    @(posedge clk); #1;
    ref_mem[10'h200] = 8'h44;
    ref_mem[10'h201] = 8'h33;
    for (int i = 0; i < 4; i++) check("mr_mem", 32'(ram[10'h200 + 10'(i)]),
                                      32'(ref_mem[10'h200 + 10'(i)]));
    run_op(4'd3, 32'h200, 32'h0, 32'h0, 5'd11, 1'b1);

    for (int i = 0; i < 80; i++) begin
      op = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 3) == 0) addr = 32'hFFFF_FFFC + 32'($urandom_range(0, 3));
      else addr = 32'h300 + 32'($urandom_range(0, 15));
      run_op(op, addr, $urandom, $urandom, 5'($urandom), 1'($urandom));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
